// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO responder and its
// master-side counterpart.
package mdio_pkg;

    typedef enum logic [3:0] {
        S_PRE   = 4'd0,
        S_ST2   = 4'd1,
        S_OP    = 4'd2,
        S_PHYAD = 4'd3,
        S_REGAD = 4'd4,
        S_TA    = 4'd5,
        S_RDATA = 4'd6,
        S_WDATA = 4'd7,
        S_SKIP  = 4'd8
    } mdio_state_e;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST_CODE  = 2'b01;

    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;
    localparam int ADDR_BITS = 5;

    function automatic logic [4:0] bit_cnt_inc(input logic [4:0] cnt);
        return cnt + 5'd1;
    endfunction

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO pad and register-port bundle between the responder and its environment.
interface mdio_phy_responder_if;
    import mdio_pkg::*;

    logic                 mdc;
    logic                 mdio_i;
    logic                 mdio_o;
    logic                 mdio_oe;
    logic [ADDR_BITS-1:0] phy_addr;
    logic [ADDR_BITS-1:0] reg_addr;
    logic                 reg_rd_en;
    logic [DATA_BITS-1:0] reg_rdata;
    logic                 reg_wr_en;
    logic [DATA_BITS-1:0] reg_wdata;
    logic                 frame_err;

    modport slave (
        input  mdc, mdio_i, phy_addr, reg_rdata,
        output mdio_o, mdio_oe, reg_addr, reg_rd_en, reg_wr_en, reg_wdata, frame_err
    );

    modport master (
        output mdc, mdio_i, phy_addr, reg_rdata,
        input  mdio_o, mdio_oe, reg_addr, reg_rd_en, reg_wr_en, reg_wdata, frame_err
    );

endinterface

// File: rtl/mdio_edge_sync.sv
// Brings MDC/MDIO into the ACLK domain and derives single-cycle MDC edge pulses.
module mdio_edge_sync (
    input  logic ACLK,
    input  logic ARESET,
    input  logic mdc,
    input  logic mdio,
    output logic rise,
    output logic fall,
    output logic mdio_s
);

    logic [1:0] mdc_sync_r;
    logic [1:0] mdio_sync_r;
    logic       mdc_d_r;
    logic       mdc_s;

    // two-flop synchronizers plus one delayed MDC copy for edge detection
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mdc_sync_r  <= 2'b00;
            mdio_sync_r <= 2'b00;
            mdc_d_r     <= 1'b0;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[0], mdc};
            mdio_sync_r <= {mdio_sync_r[0], mdio};
            mdc_d_r     <= mdc_sync_r[1];
        end
    end

    assign mdc_s  = mdc_sync_r[1];
    assign mdio_s = mdio_sync_r[1];
    assign rise   = mdc_s & ~mdc_d_r;
    assign fall   = ~mdc_s & mdc_d_r;

endmodule

// File: rtl/mdio_phy_responder.sv
// PHY-side Clause 22 MDIO responder: decodes frames for this PHY address and
// bridges them to a 32x16 register port, returning read data on MDIO.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter int PRE_MIN  = 32,
    parameter bit BCAST_EN = 1'b0
) (
    input  logic ACLK,
    input  logic ARESET,
    mdio_phy_responder_if.slave bus
);

    logic rise_s;
    logic fall_s;
    logic mdio_s;

    mdio_edge_sync u_sync (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .mdc    (bus.mdc),
        .mdio   (bus.mdio_i),
        .rise   (rise_s),
        .fall   (fall_s),
        .mdio_s (mdio_s)
    );

    mdio_state_e          state_r;
    logic [5:0]           pre_cnt_r;
    logic [4:0]           bit_cnt_r;
    logic [1:0]           op_r;
    logic [ADDR_BITS-1:0] phyad_r;
    logic [ADDR_BITS-1:0] regad_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 rd_latch_r;

    logic                 mdio_o_r;
    logic                 mdio_oe_r;
    logic [ADDR_BITS-1:0] reg_addr_r;
    logic                 reg_rd_en_r;
    logic                 reg_wr_en_r;
    logic [DATA_BITS-1:0] reg_wdata_r;
    logic                 frame_err_r;

    logic                 is_rd_s;
    logic                 match_s;
    logic [ADDR_BITS-1:0] regad_next_s;
    logic [DATA_BITS-1:0] shreg_next_s;

    // address match; broadcast PHYAD 0 only ever accepts writes
    always_comb begin
        is_rd_s      = (op_r == OP_READ);
        regad_next_s = {regad_r[ADDR_BITS-2:0], mdio_s};
        shreg_next_s = {shreg_r[DATA_BITS-2:0], mdio_s};
        if (BCAST_EN && (phyad_r == 5'd0)) begin
            match_s = ~is_rd_s;
        end else begin
            match_s = (phyad_r == bus.phy_addr);
        end
    end

    // frame decoder, pad drivers and register-port strobes
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r     <= S_PRE;
            pre_cnt_r   <= 6'd0;
            bit_cnt_r   <= 5'd0;
            op_r        <= 2'b00;
            phyad_r     <= 5'd0;
            regad_r     <= 5'd0;
            shreg_r     <= 16'h0000;
            rd_latch_r  <= 1'b0;
            mdio_o_r    <= 1'b0;
            mdio_oe_r   <= 1'b0;
            reg_addr_r  <= 5'd0;
            reg_rd_en_r <= 1'b0;
            reg_wr_en_r <= 1'b0;
            reg_wdata_r <= 16'h0000;
            frame_err_r <= 1'b0;
        end else begin
            reg_rd_en_r <= 1'b0;
            reg_wr_en_r <= 1'b0;
            frame_err_r <= 1'b0;
            rd_latch_r  <= reg_rd_en_r;
            if (rd_latch_r) begin
                shreg_r <= bus.reg_rdata;
            end

            case (state_r)
                S_PRE: begin
                    if (rise_s) begin
                        if (mdio_s) begin
                            if (pre_cnt_r != 6'd32) begin
                                pre_cnt_r <= pre_cnt_r + 6'd1;
                            end
                        end else if (pre_cnt_r >= 6'(PRE_MIN)) begin
                            pre_cnt_r <= 6'd0;
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_ST2;
                        end else begin
                            pre_cnt_r <= 6'd0;
                        end
                    end
                end

                S_ST2: begin
                    if (rise_s) begin
                        bit_cnt_r <= 5'd0;
                        if (mdio_s == ST_CODE[0]) begin
                            state_r <= S_OP;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= S_PRE;
                        end
                    end
                end

                S_OP: begin
                    if (rise_s) begin
                        op_r <= {op_r[0], mdio_s};
                        if (bit_cnt_r == 5'd1) begin
                            bit_cnt_r <= 5'd0;
                            if (({op_r[0], mdio_s} == OP_READ) || ({op_r[0], mdio_s} == OP_WRITE)) begin
                                state_r <= S_PHYAD;
                            end else begin
                                frame_err_r <= 1'b1;
                                state_r     <= S_PRE;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
                        end
                    end
                end

                S_PHYAD: begin
                    if (rise_s) begin
                        phyad_r <= {phyad_r[ADDR_BITS-2:0], mdio_s};
                        if (bit_cnt_r == 5'(ADDR_BITS - 1)) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_REGAD;
                        end else begin
                            bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
                        end
                    end
                end

                S_REGAD: begin
                    if (rise_s) begin
                        regad_r <= regad_next_s;
                        if (bit_cnt_r == 5'(ADDR_BITS - 1)) begin
                            bit_cnt_r  <= 5'd0;
                            reg_addr_r <= regad_next_s;
                            if (match_s) begin
                                reg_rd_en_r <= is_rd_s;
                                state_r     <= S_TA;
                            end else begin
                                state_r <= S_SKIP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
                        end
                    end
                end

                // reads turn the bus around on falls; writes just let two rises pass
                S_TA: begin
                    if (is_rd_s) begin
                        if (fall_s) begin
                            if (bit_cnt_r == 5'(TA_BITS - 1)) begin
                                mdio_oe_r <= 1'b1;
                                mdio_o_r  <= 1'b0;
                                bit_cnt_r <= 5'd0;
                                state_r   <= S_RDATA;
                            end else begin
                                bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
                            end
                        end
                    end else if (rise_s) begin
                        if (bit_cnt_r == 5'(TA_BITS - 1)) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_WDATA;
                        end else begin
                            bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
                        end
                    end
                end

                S_RDATA: begin
                    if (fall_s) begin
                        if (bit_cnt_r == 5'(DATA_BITS)) begin
                            mdio_oe_r <= 1'b0;
                            mdio_o_r  <= 1'b0;
                            bit_cnt_r <= 5'd0;
                            pre_cnt_r <= 6'd0;
                            state_r   <= S_PRE;
                        end else begin
                            mdio_o_r  <= shreg_r[DATA_BITS-1];
                            shreg_r   <= {shreg_r[DATA_BITS-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
                        end
                    end
                end

                S_WDATA: begin
                    if (rise_s) begin
                        shreg_r <= shreg_next_s;
                        if (bit_cnt_r == 5'(DATA_BITS - 1)) begin
                            reg_wdata_r <= shreg_next_s;
                            reg_wr_en_r <= 1'b1;
                            bit_cnt_r   <= 5'd0;
                            pre_cnt_r   <= 6'd0;
                            state_r     <= S_PRE;
                        end else begin
                            bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
                        end
                    end
                end

                S_SKIP: begin
                    if (rise_s) begin
                        if (bit_cnt_r == 5'(TA_BITS + DATA_BITS - 1)) begin
                            bit_cnt_r <= 5'd0;
                            pre_cnt_r <= 6'd0;
                            state_r   <= S_PRE;
                        end else begin
                            bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
                        end
                    end
                end

                default: begin
                    mdio_oe_r <= 1'b0;
                    mdio_o_r  <= 1'b0;
                    bit_cnt_r <= 5'd0;
                    pre_cnt_r <= 6'd0;
                    state_r   <= S_PRE;
                end
            endcase
        end
    end

    assign bus.mdio_o    = mdio_o_r;
    assign bus.mdio_oe   = mdio_oe_r;
    assign bus.reg_addr  = reg_addr_r;
    assign bus.reg_rd_en = reg_rd_en_r;
    assign bus.reg_wr_en = reg_wr_en_r;
    assign bus.reg_wdata = reg_wdata_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench: a behavioural MDIO master drives two responders (PHY 1 without
// broadcast, PHY 2 with broadcast) sharing one pulled-up MDIO line.
module tb_mdio_phy_responder;
    import mdio_pkg::*;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    mdio_phy_responder_if bif0 ();
    mdio_phy_responder_if bif1 ();

    mdio_phy_responder #(.PRE_MIN(32), .BCAST_EN(1'b0)) u0 (.ACLK(ACLK), .ARESET(ARESET), .bus(bif0));
    mdio_phy_responder #(.PRE_MIN(32), .BCAST_EN(1'b1)) u1 (.ACLK(ACLK), .ARESET(ARESET), .bus(bif1));

    logic mdc = 1'b0;
    logic m_oe = 1'b1;
    logic m_out = 1'b1;
    logic mdio_bus;
    logic [15:0] rdata0 = 16'h0000;
    logic [15:0] rdata1 = 16'h0000;

    assign mdio_bus = bif0.mdio_oe ? bif0.mdio_o :
                      (bif1.mdio_oe ? bif1.mdio_o : (m_oe ? m_out : 1'b1));
    assign bif0.mdc = mdc;
    assign bif1.mdc = mdc;
    assign bif0.mdio_i = mdio_bus;
    assign bif1.mdio_i = mdio_bus;
    assign bif0.phy_addr = 5'h01;
    assign bif1.phy_addr = 5'h02;
    assign bif0.reg_rdata = rdata0;
    assign bif1.reg_rdata = rdata1;

    function automatic logic [15:0] reg_val(input logic [4:0] a);
        case (a)
            5'd2:    return 16'h1234;
            5'd7:    return 16'h8001;
            default: return 16'hA5A5;
        endcase
    endfunction

    // register file: data valid the cycle after the read strobe
    always @(posedge ACLK) begin
        if (bif0.reg_rd_en) rdata0 <= reg_val(bif0.reg_addr);
        if (bif1.reg_rd_en) rdata1 <= reg_val(bif1.reg_addr);
    end

    int wr_cnt[2], rd_cnt[2], err_cnt[2], oe_cyc[2];
    int wr_b[2], rd_b[2], err_b[2], oe_b[2];
    int both_cnt = 0;
    logic [4:0]  waddr[2];
    logic [15:0] wdata[2];

    // strobe monitors, sampled away from the active edge
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bif0.reg_wr_en) begin wr_cnt[0]++; waddr[0] = bif0.reg_addr; wdata[0] = bif0.reg_wdata; end
            if (bif1.reg_wr_en) begin wr_cnt[1]++; waddr[1] = bif1.reg_addr; wdata[1] = bif1.reg_wdata; end
            if (bif0.reg_rd_en) rd_cnt[0]++;
            if (bif1.reg_rd_en) rd_cnt[1]++;
            if (bif0.frame_err) err_cnt[0]++;
            if (bif1.frame_err) err_cnt[1]++;
            if (bif0.mdio_oe) oe_cyc[0]++;
            if (bif1.mdio_oe) oe_cyc[1]++;
            if ((bif0.reg_rd_en && bif0.reg_wr_en) || (bif1.reg_rd_en && bif1.reg_wr_en)) both_cnt++;
        end
    end

    int n_total = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        for (int k = 0; k < 2; k++) begin
            wr_b[k] = wr_cnt[k]; rd_b[k] = rd_cnt[k]; err_b[k] = err_cnt[k]; oe_b[k] = oe_cyc[k];
        end
    endtask

    logic oe_smp, ta1_oe, ta2_oe, ta2_val, end_oe;
    logic [15:0] rd_word;

    // one MDC period: master drives after the fall, samples just before the rise
    task automatic bit_cycle(input logic drv, input logic val, output logic smp);
        mdc = 1'b0; m_oe = drv; m_out = val;
        repeat (4) @(posedge ACLK);
        #1;
        smp = mdio_bus;
        oe_smp = bif0.mdio_oe | bif1.mdio_oe;
        mdc = 1'b1;
        repeat (4) @(posedge ACLK);
        #1;
    endtask

    task automatic send_frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                              input logic [4:0] ra, input logic [15:0] wd, input int abort_bit);
        logic s;
        for (int i = 0; i < npre; i++) bit_cycle(1'b1, 1'b1, s);
        bit_cycle(1'b1, 1'b0, s);
        bit_cycle(1'b1, 1'b1, s);
        for (int i = 1; i >= 0; i--) bit_cycle(1'b1, op[i], s);
        for (int i = 4; i >= 0; i--) bit_cycle(1'b1, pa[i], s);
        for (int i = 4; i >= 0; i--) bit_cycle(1'b1, ra[i], s);
        if (op == OP_READ) begin
            bit_cycle(1'b0, 1'b0, s); ta1_oe = oe_smp;
            bit_cycle(1'b0, 1'b0, s); ta2_oe = oe_smp; ta2_val = s;
            rd_word = 16'h0000;
            for (int i = 15; i >= 0; i--) begin
                if (abort_bit == i) begin
                    chk("abort_oe_before", {31'd0, bif0.mdio_oe}, 32'd1);
                    ARESET = 1'b1;
                    @(posedge ACLK); #1;
                    chk("abort_oe", {31'd0, bif0.mdio_oe}, 32'd0);
                    chk("abort_o", {31'd0, bif0.mdio_o}, 32'd0);
                    chk("abort_rd_wr_err", {29'd0, bif0.reg_rd_en, bif0.reg_wr_en, bif0.frame_err}, 32'd0);
                    chk("abort_addr", {27'd0, bif0.reg_addr}, 32'd0);
                    chk("abort_wdata", {16'd0, bif0.reg_wdata}, 32'd0);
                    ARESET = 1'b0;
                    m_oe = 1'b1; m_out = 1'b0;
                    bit_cycle(1'b1, 1'b0, s);
                    return;
                end
                bit_cycle(1'b0, 1'b0, s);
                rd_word[i] = s;
            end
        end else begin
            bit_cycle(1'b1, 1'b1, s);
            bit_cycle(1'b1, 1'b0, s);
            for (int i = 15; i >= 0; i--) bit_cycle(1'b1, wd[i], s);
        end
        // trailing driven 0 keeps idle bits out of the next preamble count
        bit_cycle(1'b1, 1'b0, s);
        end_oe = oe_smp;
    endtask

    initial begin
        logic s;
        for (int k = 0; k < 2; k++) begin
            wr_cnt[k] = 0; rd_cnt[k] = 0; err_cnt[k] = 0; oe_cyc[k] = 0;
        end
        repeat (4) @(posedge ACLK);
        #1;
        chk("rst_oe", {31'd0, bif0.mdio_oe}, 32'd0);
        chk("rst_o", {31'd0, bif0.mdio_o}, 32'd0);
        chk("rst_strobes", {29'd0, bif0.reg_rd_en, bif0.reg_wr_en, bif0.frame_err}, 32'd0);
        chk("rst_addr", {27'd0, bif0.reg_addr}, 32'd0);
        chk("rst_wdata", {16'd0, bif0.reg_wdata}, 32'd0);
        ARESET = 1'b0;
        repeat (4) @(posedge ACLK);
        #1;

        snap(); send_frame(32, OP_WRITE, 5'h01, 5'h04, 16'hBEEF, -1);
        chk("wr_count", wr_cnt[0] - wr_b[0], 32'd1);
        chk("wr_addr", {27'd0, waddr[0]}, 32'd4);
        chk("wr_data", {16'd0, wdata[0]}, 32'h0000BEEF);
        chk("wr_oe", oe_cyc[0] - oe_b[0] + oe_cyc[1] - oe_b[1], 32'd0);
        chk("wr_no_rd", rd_cnt[0] - rd_b[0], 32'd0);
        chk("wr_other_phy", wr_cnt[1] - wr_b[1], 32'd0);

        snap(); send_frame(32, OP_READ, 5'h01, 5'h02, 16'h0000, -1);
        chk("rd_count", rd_cnt[0] - rd_b[0], 32'd1);
        chk("rd_ta1_oe", {31'd0, ta1_oe}, 32'd0);
        chk("rd_ta2_oe", {31'd0, ta2_oe}, 32'd1);
        chk("rd_ta2_val", {31'd0, ta2_val}, 32'd0);
        chk("rd_data", {16'd0, rd_word}, 32'h00001234);
        chk("rd_end_oe", {31'd0, end_oe}, 32'd0);
        chk("rd_no_wr", wr_cnt[0] - wr_b[0], 32'd0);

        snap(); send_frame(32, OP_READ, 5'h03, 5'h02, 16'h0000, -1);
        chk("mis_rd", rd_cnt[0] - rd_b[0] + rd_cnt[1] - rd_b[1], 32'd0);
        chk("mis_wr", wr_cnt[0] - wr_b[0] + wr_cnt[1] - wr_b[1], 32'd0);
        chk("mis_oe", oe_cyc[0] - oe_b[0] + oe_cyc[1] - oe_b[1], 32'd0);
        chk("mis_data", {16'd0, rd_word}, 32'h0000FFFF);

        snap(); send_frame(32, OP_READ, 5'h01, 5'h07, 16'h0000, -1);
        chk("rd7_count", rd_cnt[0] - rd_b[0], 32'd1);
        chk("rd7_data", {16'd0, rd_word}, 32'h00008001);

        snap(); send_frame(31, OP_WRITE, 5'h01, 5'h09, 16'h1357, -1);
        chk("short_pre", wr_cnt[0] - wr_b[0], 32'd0);
        snap(); send_frame(32, OP_WRITE, 5'h01, 5'h09, 16'h1357, -1);
        chk("full_pre", wr_cnt[0] - wr_b[0], 32'd1);
        chk("full_pre_data", {11'd0, waddr[0], wdata[0]}, 32'h00091357);

        snap(); send_frame(32, 2'b11, 5'h01, 5'h05, 16'h0001, -1);
        chk("badop_err", err_cnt[0] - err_b[0], 32'd1);
        chk("badop_strobes", wr_cnt[0] - wr_b[0] + rd_cnt[0] - rd_b[0], 32'd0);
        snap(); send_frame(32, OP_WRITE, 5'h01, 5'h05, 16'h0001, -1);
        chk("after_badop", wr_cnt[0] - wr_b[0], 32'd1);
        chk("after_badop_data", {11'd0, waddr[0], wdata[0]}, 32'h00050001);

        snap();
        for (int i = 0; i < 32; i++) bit_cycle(1'b1, 1'b1, s);
        bit_cycle(1'b1, 1'b0, s);
        bit_cycle(1'b1, 1'b0, s);
        bit_cycle(1'b1, 1'b0, s);
        chk("st_err", err_cnt[0] - err_b[0], 32'd1);

        send_frame(32, OP_READ, 5'h01, 5'h02, 16'h0000, 7);
        chk("abort_upper", {24'd0, rd_word[15:8]}, 32'h00000012);
        snap(); send_frame(32, OP_WRITE, 5'h01, 5'h03, 16'h8000, -1);
        chk("post_rst_wr", wr_cnt[0] - wr_b[0], 32'd1);
        chk("post_rst_data", {11'd0, waddr[0], wdata[0]}, 32'h00038000);

        snap(); send_frame(32, OP_WRITE, 5'h00, 5'h06, 16'h00FF, -1);
        chk("bc_wr", wr_cnt[1] - wr_b[1], 32'd1);
        chk("bc_wr_data", {11'd0, waddr[1], wdata[1]}, 32'h000600FF);
        chk("bc_wr_nobc", wr_cnt[0] - wr_b[0], 32'd0);
        snap(); send_frame(32, OP_READ, 5'h00, 5'h02, 16'h0000, -1);
        chk("bc_rd", rd_cnt[0] - rd_b[0] + rd_cnt[1] - rd_b[1], 32'd0);
        chk("bc_rd_oe", oe_cyc[0] - oe_b[0] + oe_cyc[1] - oe_b[1], 32'd0);

        chk("rd_wr_exclusive", both_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side IEEE 802.3 Clause 22 MDIO responder, i.e. the far end of the Serial Management Interface master.
- Oversamples MDC/MDIO in the ACLK domain, decodes read and write frames addressed to its PHY address, and returns read data on MDIO.
- Bridges frames to a simple 32x16 register-port interface.
- Used as a PHY model in system benches and as the management slave in FPGA-to-FPGA links.

Parameters:
- PRE_MIN, 32, consecutive 1-bits required before ST is accepted (1..32).
- BCAST_EN, 0, when 1, writes to PHYAD 0 are also accepted; reads to PHYAD 0 are never answered.

Ports:
- ACLK  in  1  system clock; must be at least 4x MDC frequency.
- ARESET  in  1  synchronous, active-high reset.
- mdc  in  1  management clock, asynchronous to ACLK.
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO pad output value.
- mdio_oe  out  1  MDIO pad output enable (1 = drive).
- phy_addr  in  5  this PHY's address; quasi-static.
- reg_addr  out  5  register index of the current frame.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rdata  in  16  read data, valid the cycle after reg_rd_en.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wdata  out  16  write data, valid with reg_wr_en.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Sync: mdc and mdio_i each pass through a 2-flop synchronizer. rise = mdc_s & ~mdc_d; fall = ~mdc_s & mdc_d.
- Sampling and driving: MDIO is sampled only on rise. mdio_o and mdio_oe change only on fall.
- Reset values: mdio_oe=0, mdio_o=0, reg_rd_en=0, reg_wr_en=0, frame_err=0, reg_addr=0, reg_wdata=0, state=PRE, preamble count=0.
- State PRE: on each rise, a 1 increments a saturating preamble counter; a 0 clears it. When counter >= PRE_MIN and a 0 is sampled, go to ST2.
- State ST2: expects 1 (completing ST=01). On 0, pulse frame_err and go to PRE with counter=0.
- State OP: captures 2 bits. 10 = read, 01 = write. 00 or 11 -> frame_err, then PRE.
- State PHYAD: captures 5 bits, MSB first.
- State REGAD: captures 5 bits. On the rise sampling the last bit:
  - match = (PHYAD==phy_addr) or (BCAST_EN and write and PHYAD==0).
  - reg_addr updates.
  - For a matched read, reg_rd_en pulses the next cycle; reg_rdata is latched into the shift register one cycle later.
- State TA, two bit times:
  - Matched read: first TA fall keeps oe=0; second fall sets oe=1, o=0.
  - Write: TA bits are ignored, no check.
  - Unmatched: go to SKIP.
- State RDATA: on each following fall, drive shift-register MSB, 16 bits (15..0). On the fall after bit 0 has been sampled, oe=0, then return to PRE.
- State WDATA: shift 16 bits on rises. One cycle after the 16th rise, reg_wdata is valid and reg_wr_en pulses once. Then return to PRE.
- State SKIP: counts 18 rises (TA + data) with oe=0, then PRE. No strobes are issued.
- A bit counter (5 bits) is shared by all states and reloaded on every state entry.
- No preamble suppression across frames: every frame needs PRE_MIN ones. Read-data or idle ones are not counted while in a non-PRE state.
- Boundaries:
  - ARESET mid-read: mdio_oe drops the next ACLK cycle, regardless of MDC.
  - phy_addr changing mid-frame is undefined; it is sampled only at the end of REGAD.
  - reg_rd_en and reg_wr_en are never high in the same cycle.
  - mdio_oe is never 1 outside TA2/RDATA.

Decomposition:
- Shared package mdio_pkg:
  - state enum.
  - OP_READ=2'b10, OP_WRITE=2'b01, ST_CODE=2'b01.
  - TA_BITS=2, DATA_BITS=16, ADDR_BITS=5.
- Natural sub-module mdio_edge_sync: 2-flop sync of mdc/mdio, producing rise/fall/mdio_s. It is reused by the master-side block.

Test Plan:
- Write frame: phy_addr=5'h01, MDC=ACLK/8, 32 ones + 01 01 00001 00100 10 0xBEEF -> exactly one reg_wr_en, with reg_addr=4 and reg_wdata=16'hBEEF; mdio_oe stays 0 throughout.
- Read frame: phy_addr=1, REGAD=2, reg_rdata returns 0x1234 -> oe rises on the 2nd TA fall, o=0; bits 0x1234 MSB first are sampled correctly on the master's rises; oe=0 after bit 0.
- Address mismatch: PHYAD=5'h03 read -> no strobes, oe never asserted; the next valid frame to PHYAD 1 is served normally.
- Short preamble with PRE_MIN=32: 31 ones then a frame -> frame ignored, no strobe; the next frame with 32 ones is served.
- Bad opcode 11 -> frame_err pulses once, no strobes; the following good write is accepted.
- ARESET asserted at data bit 8 of a read -> mdio_oe=0 the next cycle, all outputs at reset values; the post-reset write frame is accepted.
- BCAST_EN=1: write to PHYAD 0 is accepted; read to PHYAD 0 leaves oe=0.
